lot_display: RTL and testbench

- Downstream consumer of the car-park occupancy count.
- Takes the binary car count and drives a 4-digit, time-multiplexed, common-anode seven-segment display: two digits show cars present, two digits show free spaces.
- Also raises registered full/empty status flags for gate or LED logic.
- Samples the count once per scan frame so a frame never shows a mix of old and new values.

---
 rtl/lot_display.sv | 164 ++++++++++++++++
 tb/tb_lot_display.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lot_display.sv
// Four-digit multiplexed seven-segment readout of car-park occupancy and free spaces,
// plus registered full/empty flags. Optional full-lot blinking is enabled by LOT_BLINK_EN.
`timescale 1ns/1ps

module lot_display #(
  parameter int COUNT_W      = 4,
  parameter int CAPACITY     = 10,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] car_count,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               full,
  output logic               empty
);

  localparam int              RC_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);
  localparam logic [31:0]     CAP_32  = 32'(CAPACITY);
  localparam logic [6:0]      CAP_7   = 7'(CAPACITY);
  localparam logic [6:0]      SEG_OFF = 7'b1111111;

  if (CAPACITY < 1 || CAPACITY > 99 || REFRESH_DIV < 2 || BLINK_FRAMES < 1) begin : g_param_check
    $error("lot_display: parameter out of range");
  end

  // Count shown on the display is clamped to two decimal digits.
  function automatic logic [6:0] sat_disp(input logic [31:0] v);
    return (v > 32'd99) ? 7'd99 : 7'(v);
  endfunction

  // Free spaces saturate at zero when the lot is over-counted.
  function automatic logic [6:0] sat_free(input logic [31:0] v);
    return (v < CAP_32) ? (CAP_7 - 7'(v)) : 7'd0;
  endfunction

  function automatic logic [3:0] tens_of(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  logic [RC_W-1:0]    rc;
  logic [1:0]         idx;
  logic [COUNT_W-1:0] cnt_q;
  logic               frame_end;
  logic               full_nxt;
  logic [31:0]        cnt_ext;
  logic [31:0]        cc_ext;
  logic [6:0]         disp_cnt;
  logic [6:0]         free_cnt;
  logic [3:0]         digit;
  logic               blank_p0;
  logic [3:0]         an_p0;
  logic [6:0]         seg_p0;
  logic               dark;

  assign cnt_ext   = 32'(cnt_q);
  assign cc_ext    = 32'(car_count);
  assign frame_end = (rc == RC_LAST) && (idx == 2'd3);
  assign full_nxt  = (cc_ext >= CAP_32);
  assign disp_cnt  = sat_disp(cnt_ext);
  assign free_cnt  = sat_free(cnt_ext);

`ifdef LOT_BLINK_EN
  localparam int              FC_W    = $clog2(BLINK_FRAMES) + 1;
  localparam logic [FC_W-1:0] FC_HALF = FC_W'(BLINK_FRAMES);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(2 * BLINK_FRAMES - 1);

  logic [FC_W-1:0] fc;

  // Frames 0..BLINK_FRAMES-1 of each period are lit, the rest dark.
  assign dark = full && (fc >= FC_HALF);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fc <= '0;
    end else if (frame_end) begin
      if ((full_nxt && !full) || (fc == FC_LAST)) begin
        fc <= '0;
      end else begin
        fc <= fc + FC_W'(1);
      end
    end
  end
`else
  assign dark = 1'b0;
`endif

  // Stage p0: digit selection from the current scan index and frame snapshot.
  always_comb begin
    digit    = 4'd0;
    blank_p0 = 1'b0;
    case (idx)
      2'd0: digit = ones_of(disp_cnt);
      2'd1: begin
        digit    = tens_of(disp_cnt);
        blank_p0 = (digit == 4'd0);
      end
      2'd2: digit = ones_of(free_cnt);
      default: begin
        digit    = tens_of(free_cnt);
        blank_p0 = (digit == 4'd0);
      end
    endcase
    an_p0  = ~(4'b0001 << idx);
    seg_p0 = blank_p0 ? SEG_OFF : seg7(digit);
    if (dark) begin
      an_p0  = 4'b1111;
      seg_p0 = SEG_OFF;
    end
  end

  // Stage p1: registered display drive, scan control and frame snapshot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rc    <= '0;
      idx   <= 2'd0;
      cnt_q <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      an    <= 4'b1111;
      seg   <= SEG_OFF;
    end else begin
      an  <= an_p0;
      seg <= seg_p0;
      if (rc == RC_LAST) begin
        rc  <= '0;
        idx <= idx + 2'd1;
      end else begin
        rc <= rc + RC_W'(1);
      end
      if (frame_end) begin
        cnt_q <= car_count;
        full  <= full_nxt;
        empty <= (car_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_lot_display.sv
// Directed bench for lot_display: reset, frame snapshot, mid-frame changes, saturation,
// mid-frame reset and (with LOT_BLINK_EN) full-lot blinking.
`timescale 1ns/1ps

module tb_lot_display;

  localparam int COUNT_W      = 4;
  localparam int CAPACITY     = 10;
  localparam int REFRESH_DIV  = 4;
  localparam int BLINK_FRAMES = 2;

`ifdef LOT_BLINK_EN
  localparam logic BLINK = 1'b1;
`else
  localparam logic BLINK = 1'b0;
`endif

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  logic               clk = 1'b0;
  logic               rst;
  logic [COUNT_W-1:0] car_count;
  logic [3:0]         an;
  logic [6:0]         seg;
  logic               full;
  logic               empty;

  int n_pass   = 0;
  int n_total  = 0;
  int frame_no = 0;

  lot_display #(
    .COUNT_W     (COUNT_W),
    .CAPACITY    (CAPACITY),
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .car_count(car_count),
    .an       (an),
    .seg      (seg),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One digit slot is REFRESH_DIV cycles; check an/seg twice inside it.
  task automatic check_digit(input int d, input logic [6:0] exp_seg, input logic dk);
    logic [3:0] exp_an;
    logic [6:0] exp_s;
    exp_an = dk ? 4'b1111 : ~(4'b0001 << d);
    exp_s  = dk ? BL : exp_seg;
    for (int s = 0; s < REFRESH_DIV; s++) begin
      step();
      if (s == 1 || s == REFRESH_DIV - 1) begin
        check($sformatf("f%0d_d%0d_s%0d_an", frame_no, d, s), 32'(an), 32'(exp_an));
        check($sformatf("f%0d_d%0d_s%0d_seg", frame_no, d, s), 32'(seg), 32'(exp_s));
      end
    end
    if (d == 3) frame_no++;
  endtask

  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input logic dk);
    check_digit(0, s0, dk);
    check_digit(1, s1, dk);
    check_digit(2, s2, dk);
    check_digit(3, s3, dk);
  endtask

  task automatic check_flags(input string tag, input logic exp_full, input logic exp_empty);
    check({tag, "_full"}, 32'(full), 32'(exp_full));
    check({tag, "_empty"}, 32'(empty), 32'(exp_empty));
  endtask

  initial begin
    rst       = 1'b0;
    car_count = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d_an", i), 32'(an), 32'hF);
      check($sformatf("rst%0d_seg", i), 32'(seg), 32'(BL));
      check_flags($sformatf("rst%0d", i), 1'b0, 1'b1);
    end

    rst       = 1'b1;
    car_count = 4'd7;
    // Frame 0: snapshot 0 -> count "_0", free "10".
    check_digit(0, S0, 1'b0);
    check_digit(1, BL, 1'b0);
    check_digit(2, S0, 1'b0);
    check_flags("f0_mid", 1'b0, 1'b1);
    check_digit(3, S1, 1'b0);
    check_flags("f0_end", 1'b0, 1'b0);

    // Frame 1: 7 / 3, input changes to 2 while idx==1.
    check_digit(0, S7, 1'b0);
    check_digit(1, BL, 1'b0);
    car_count = 4'd2;
    check_digit(2, S3, 1'b0);
    check_digit(3, BL, 1'b0);

    // Frame 2: 2 / 8, lot becomes full at its end.
    check_digit(0, S2, 1'b0);
    check_digit(1, BL, 1'b0);
    car_count = 4'd10;
    check_digit(2, S8, 1'b0);
    check_flags("f2_pre", 1'b0, 1'b0);
    check_digit(3, BL, 1'b0);
    check_flags("f2_end", 1'b1, 1'b0);

    // Frame 3: 10 / 0; over-capacity count captured at its end.
    car_count = 4'd15;
    check_frame(S0, S1, S0, BL, 1'b0);
    check_flags("f3_end", 1'b1, 1'b0);

    // Frame 4: 15 / 0 with free saturated.
    check_frame(S5, S1, S0, BL, 1'b0);

    // Frame 5: reset asserted once idx reaches 2.
    check_digit(0, S5, 1'b0);
    check_digit(1, S1, 1'b0);
    rst = 1'b0;
    step();
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'(BL));
    check_flags("midrst", 1'b0, 1'b1);
    rst       = 1'b1;
    car_count = 4'd10;
    frame_no  = 100;

    // Restart frame shows count 0, then full lot frames (blinking when enabled).
    check_frame(S0, BL, S0, S1, 1'b0);
    check_flags("r0_end", 1'b1, 1'b0);
    check_frame(S0, S1, S0, BL, 1'b0);
    check_frame(S0, S1, S0, BL, 1'b0);
    check_frame(S0, S1, S0, BL, BLINK);
    car_count = 4'd9;
    check_frame(S0, S1, S0, BL, BLINK);
    check_flags("r4_end", 1'b0, 1'b0);

    // Count 9 / free 1: steady display from now on.
    check_frame(S9, BL, S1, BL, 1'b0);
    check_frame(S9, BL, S1, BL, 1'b0);
    check_frame(S9, BL, S1, BL, 1'b0);
    check_flags("r7_end", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
